// File: rtl/mfp_io_debouncer.sv
// Debouncer for the 18 slide switches and 5 pushbuttons feeding the GPIO slave.
// Each input is synchronized, then a new level is accepted after STABLE_TICKS consecutive mismatching sample ticks.
module mfp_io_debouncer #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [17:0] IO_RawSwitches,
  input  logic [4:0]  IO_RawButtons,
  output logic [17:0] IO_Switches,
  output logic [4:0]  IO_Buttons,
  output logic [4:0]  IO_ButtonPress,
  output logic [4:0]  IO_ButtonRelease
);

  localparam int          N         = 23;
  localparam logic [19:0] PRESC_MAX = 20'(TICK_DIV - 1);
  localparam logic [3:0]  CNT_MAX   = 4'(STABLE_TICKS - 1);

  logic [N-1:0]      raw;
  logic [N-1:0]      sync1;
  logic [N-1:0]      synced;
  logic [N-1:0]      deb;
  logic [N-1:0]      deb_next;
  logic [N-1:0][3:0] cnt;
  logic [N-1:0][3:0] cnt_next;
  logic [19:0]       presc;
  logic              tick;
  logic [4:0]        press_q;
  logic [4:0]        release_q;

  // Buttons occupy the top five bits so the switch field maps straight to [17:0].
  assign raw = {IO_RawButtons, IO_RawSwitches};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1  <= '0;
      synced <= '0;
    end else begin
      sync1  <= raw;
      synced <= sync1;
    end
  end

  // With TICK_DIV=1 the compare is against 0 and the counter never leaves 0, so tick stays high.
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 20'd1;
    end
  end

  always_comb begin
    deb_next = deb;
    cnt_next = cnt;
    for (int i = 0; i < N; i++) begin
      if (synced[i] == deb[i]) begin
        cnt_next[i] = 4'd0;
      end else if (tick) begin
        if (cnt[i] == CNT_MAX) begin
          deb_next[i] = synced[i];
          cnt_next[i] = 4'd0;
        end else begin
          cnt_next[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // Pulses are registered on the same edge as deb so they line up with the new level.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      deb       <= '0;
      cnt       <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      deb       <= deb_next;
      cnt       <= cnt_next;
      press_q   <= deb_next[22:18] & ~deb[22:18];
      release_q <= ~deb_next[22:18] & deb[22:18];
    end
  end

  assign IO_Switches      = deb[17:0];
  assign IO_Buttons       = deb[22:18];
  assign IO_ButtonPress   = press_q;
  assign IO_ButtonRelease = release_q;

endmodule
